// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle CPU control unit.
package cu_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEM_RD = 4'd2,
    ACC_RD = 4'd3,
    RD2    = 4'd4,
    RD1    = 4'd5,
    EXEC   = 4'd6,
    WB     = 4'd7,
    MEM_WR = 4'd8,
    JUMP   = 4'd9
  } state_t;

  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b100;
  localparam logic [2:0] OP_JZ  = 3'b101;
  localparam logic [2:0] OP_JC  = 3'b110;
  localparam logic [2:0] OP_REG = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam int unsigned CZN_C = 0;
  localparam int unsigned CZN_Z = 1;
  localparam int unsigned CZN_N = 2;

  // Register-format function select inside the DI byte.
  localparam logic [4:0] DI_FUNC_MASK = 5'b1_00_00;

  typedef struct packed {
    logic       pcInc;
    logic       pcLoadEn;
    logic       diLoadEn;
    logic       irWriteEn;
    logic       trWriteEn;
    logic       memoryReadEn;
    logic       memoryWriteEn;
    logic       accumulatorWriteEn;
    logic       aRegWriteEn;
    logic       bRegWriteEn;
    logic       aluResWriteEn;
    logic       ldCZN;
    logic       PcOrTR;
    logic       reg1Or2;
    logic       regOrMem;
    logic       RegBOr0;
    logic       RegAOr0;
    logic [1:0] aluOpControl;
    logic       instrDone;
  } ctrl_t;

  // JMP always jumps; JZ/JC test their flag; N is never a jump condition.
  function automatic logic jumpTaken(input logic [2:0] opcode, input logic [2:0] czn);
    logic [2:0] mask;
    mask = '0;
    if (opcode == OP_JZ) mask[CZN_Z] = 1'b1;
    if (opcode == OP_JC) mask[CZN_C] = 1'b1;
    return (opcode == OP_JMP) || (|(czn & mask));
  endfunction

  function automatic logic isCondJump(input logic [2:0] opcode);
    return (opcode == OP_JZ) || (opcode == OP_JC);
  endfunction

endpackage

// File: rtl/cu_output_decoder.sv
// Combinational control-word decode from state, opcode, function bit and flags.
module cu_output_decoder
  import cu_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] opcode,
  input  logic       func,
  input  logic [2:0] czn,
  input  logic       active,
  output ctrl_t      ctrl
);

  // Moore strobes per state; everything held at 0 while reset is asserted.
  always_comb begin
    ctrl = '0;
    if (active) begin
      unique case (state)
        FETCH: begin
          ctrl.PcOrTR       = 1'b1;
          ctrl.memoryReadEn = 1'b1;
          ctrl.irWriteEn    = 1'b1;
          ctrl.pcInc        = 1'b1;
        end
        DECODE: begin
          ctrl.diLoadEn = 1'b1;
          if (opcode != OP_REG) begin
            ctrl.PcOrTR       = 1'b1;
            ctrl.memoryReadEn = 1'b1;
            ctrl.trWriteEn    = 1'b1;
            ctrl.pcInc        = 1'b1;
          end
          if (isCondJump(opcode) && !jumpTaken(opcode, czn)) ctrl.instrDone = 1'b1;
        end
        MEM_RD: begin
          ctrl.memoryReadEn = 1'b1;
          ctrl.bRegWriteEn  = 1'b1;
          if (opcode == OP_ADD || opcode == OP_AND) ctrl.aRegWriteEn = 1'b1;
        end
        ACC_RD: ctrl.aRegWriteEn = 1'b1;
        RD2: begin
          ctrl.reg1Or2     = 1'b1;
          ctrl.regOrMem    = 1'b1;
          ctrl.bRegWriteEn = 1'b1;
        end
        RD1: ctrl.aRegWriteEn = 1'b1;
        EXEC: begin
          ctrl.aluResWriteEn = 1'b1;
          ctrl.aluOpControl  = ALU_ADD;
          unique case (opcode)
            OP_LDA: ctrl.RegAOr0 = 1'b1;
            OP_STA: ctrl.RegBOr0 = 1'b1;
            OP_ADD: ctrl.ldCZN = 1'b1;
            OP_AND: begin
              ctrl.ldCZN        = 1'b1;
              ctrl.aluOpControl = ALU_AND;
            end
            OP_REG: begin
              ctrl.ldCZN        = 1'b1;
              ctrl.aluOpControl = func ? ALU_AND : ALU_ADD;
            end
            default: ;
          endcase
        end
        WB: begin
          ctrl.accumulatorWriteEn = 1'b1;
          ctrl.instrDone          = 1'b1;
        end
        MEM_WR: begin
          ctrl.memoryWriteEn = 1'b1;
          ctrl.instrDone     = 1'b1;
        end
        JUMP: begin
          ctrl.pcLoadEn  = 1'b1;
          ctrl.instrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the 8-bit multi-cycle CPU datapath.
module multicycle_controller
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [4:0] DiToCU,
  input  logic [2:0] CznToCU,
  output logic       pcInc,
  output logic       pcLoadEn,
  output logic       diLoadEn,
  output logic       irWriteEn,
  output logic       trWriteEn,
  output logic       memoryReadEn,
  output logic       memoryWriteEn,
  output logic       accumulatorWriteEn,
  output logic       aRegWriteEn,
  output logic       bRegWriteEn,
  output logic       aluResWriteEn,
  output logic       ldCZN,
  output logic       PcOrTR,
  output logic       reg1Or2,
  output logic       regOrMem,
  output logic       RegBOr0,
  output logic       RegAOr0,
  output logic [1:0] aluOpControl,
  output logic       instrDone
);

  state_t state, nextState;
  ctrl_t  ctrl;
  logic   func;

  // Register fields are resolved in the datapath; only the function bit matters here.
  assign func = |(DiToCU & DI_FUNC_MASK);

  // State register; reset parks the sequencer in FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= nextState;
  end

  // Next-state sequencing; the jump decision uses the flags present during DECODE.
  always_comb begin
    nextState = FETCH;
    unique case (state)
      FETCH: nextState = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_REG:                nextState = RD2;
          OP_JMP, OP_JZ, OP_JC:  nextState = jumpTaken(opcode, CznToCU) ? JUMP : FETCH;
          OP_STA:                nextState = ACC_RD;
          default:               nextState = MEM_RD;
        endcase
      end
      MEM_RD:  nextState = EXEC;
      ACC_RD:  nextState = EXEC;
      RD2:     nextState = RD1;
      RD1:     nextState = EXEC;
      EXEC:    nextState = (opcode == OP_STA) ? MEM_WR : WB;
      WB:      nextState = FETCH;
      MEM_WR:  nextState = FETCH;
      JUMP:    nextState = FETCH;
      default: nextState = FETCH;
    endcase
  end

  // Gating the decoder with rst keeps every strobe low for the whole reset window.
  cu_output_decoder uDecoder (
    .state  (state),
    .opcode (opcode),
    .func   (func),
    .czn    (CznToCU),
    .active (rst),
    .ctrl   (ctrl)
  );

  assign pcInc              = ctrl.pcInc;
  assign pcLoadEn           = ctrl.pcLoadEn;
  assign diLoadEn           = ctrl.diLoadEn;
  assign irWriteEn          = ctrl.irWriteEn;
  assign trWriteEn          = ctrl.trWriteEn;
  assign memoryReadEn       = ctrl.memoryReadEn;
  assign memoryWriteEn      = ctrl.memoryWriteEn;
  assign accumulatorWriteEn = ctrl.accumulatorWriteEn;
  assign aRegWriteEn        = ctrl.aRegWriteEn;
  assign bRegWriteEn        = ctrl.bRegWriteEn;
  assign aluResWriteEn      = ctrl.aluResWriteEn;
  assign ldCZN              = ctrl.ldCZN;
  assign PcOrTR             = ctrl.PcOrTR;
  assign reg1Or2            = ctrl.reg1Or2;
  assign regOrMem           = ctrl.regOrMem;
  assign RegBOr0            = ctrl.RegBOr0;
  assign RegAOr0            = ctrl.RegAOr0;
  assign aluOpControl       = ctrl.aluOpControl;
  assign instrDone          = ctrl.instrDone;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction expected control-word sequences from the ISA rules.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic [4:0] DiToCU;
  logic [2:0] CznToCU;
  logic pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, memoryReadEn, memoryWriteEn;
  logic accumulatorWriteEn, aRegWriteEn, bRegWriteEn, aluResWriteEn, ldCZN;
  logic PcOrTR, reg1Or2, regOrMem, RegBOr0, RegAOr0, instrDone;
  logic [1:0] aluOpControl;

  int checks = 0;
  int errors = 0;

  // Bit positions of the observed control word.
  localparam logic [19:0] W_PCINC  = 20'h1 << 19;
  localparam logic [19:0] W_PCLOAD = 20'h1 << 18;
  localparam logic [19:0] W_DILOAD = 20'h1 << 17;
  localparam logic [19:0] W_IRWR   = 20'h1 << 16;
  localparam logic [19:0] W_TRWR   = 20'h1 << 15;
  localparam logic [19:0] W_MEMRD  = 20'h1 << 14;
  localparam logic [19:0] W_MEMWR  = 20'h1 << 13;
  localparam logic [19:0] W_ACC    = 20'h1 << 12;
  localparam logic [19:0] W_AREG   = 20'h1 << 11;
  localparam logic [19:0] W_BREG   = 20'h1 << 10;
  localparam logic [19:0] W_ALURES = 20'h1 << 9;
  localparam logic [19:0] W_LDCZN  = 20'h1 << 8;
  localparam logic [19:0] W_PCORTR = 20'h1 << 7;
  localparam logic [19:0] W_R1OR2  = 20'h1 << 6;
  localparam logic [19:0] W_REGMEM = 20'h1 << 5;
  localparam logic [19:0] W_BOR0   = 20'h1 << 4;
  localparam logic [19:0] W_AOR0   = 20'h1 << 3;
  localparam logic [19:0] W_ALUAND = 20'h1 << 2;
  localparam logic [19:0] W_DONE   = 20'h1 << 0;

  logic [19:0] observed;
  assign observed = {pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, memoryReadEn,
                     memoryWriteEn, accumulatorWriteEn, aRegWriteEn, bRegWriteEn,
                     aluResWriteEn, ldCZN, PcOrTR, reg1Or2, regOrMem, RegBOr0, RegAOr0,
                     aluOpControl, instrDone};

  logic [19:0] expQ[$];

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .DiToCU(DiToCU), .CznToCU(CznToCU),
    .pcInc(pcInc), .pcLoadEn(pcLoadEn), .diLoadEn(diLoadEn), .irWriteEn(irWriteEn),
    .trWriteEn(trWriteEn), .memoryReadEn(memoryReadEn), .memoryWriteEn(memoryWriteEn),
    .accumulatorWriteEn(accumulatorWriteEn), .aRegWriteEn(aRegWriteEn),
    .bRegWriteEn(bRegWriteEn), .aluResWriteEn(aluResWriteEn), .ldCZN(ldCZN),
    .PcOrTR(PcOrTR), .reg1Or2(reg1Or2), .regOrMem(regOrMem), .RegBOr0(RegBOr0),
    .RegAOr0(RegAOr0), .aluOpControl(aluOpControl), .instrDone(instrDone)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Reference: the cycle-by-cycle strobe list of one instruction, from the ISA table.
  task automatic buildSeq(input logic [2:0] op, input logic func, input logic [2:0] cznDec);
    logic [19:0] wb;
    bit isJump, taken;
    isJump = (op >= 3'd4) && (op <= 3'd6);
    taken  = (op == 3'd4) || (op == 3'd5 && cznDec[1]) || (op == 3'd6 && cznDec[0]);
    wb     = W_ACC | W_DONE;
    expQ.delete();
    expQ.push_back(W_PCINC | W_IRWR | W_MEMRD | W_PCORTR);
    expQ.push_back(W_DILOAD | ((op != 3'd7) ? (W_PCINC | W_MEMRD | W_TRWR | W_PCORTR) : '0)
                   | ((isJump && !taken) ? W_DONE : '0));
    if (isJump) begin
      if (taken) expQ.push_back(W_PCLOAD | W_DONE);
    end else begin
      case (op)
        3'd0: begin
          expQ.push_back(W_MEMRD | W_BREG);
          expQ.push_back(W_ALURES | W_AOR0);
          expQ.push_back(wb);
        end
        3'd1: begin
          expQ.push_back(W_AREG);
          expQ.push_back(W_ALURES | W_BOR0);
          expQ.push_back(W_MEMWR | W_DONE);
        end
        3'd2, 3'd3: begin
          expQ.push_back(W_MEMRD | W_BREG | W_AREG);
          expQ.push_back(W_ALURES | W_LDCZN | ((op == 3'd3) ? W_ALUAND : '0));
          expQ.push_back(wb);
        end
        default: begin
          expQ.push_back(W_R1OR2 | W_REGMEM | W_BREG);
          expQ.push_back(W_AREG);
          expQ.push_back(W_ALURES | W_LDCZN | (func ? W_ALUAND : '0));
          expQ.push_back(wb);
        end
      endcase
    end
  endtask

  // Runs one instruction starting in FETCH (called at posedge+1). abortAt >= 0 pulls
  // reset during that cycle index and checks the aftermath.
  task automatic runInstr(input logic [2:0] op, input logic [4:0] di, input bit fixCzn,
                          input logic [2:0] cznFix, input int abortAt);
    logic [2:0] cznArr[6];
    for (int i = 0; i < 6; i++) cznArr[i] = fixCzn ? cznFix : 3'($urandom_range(0, 7));
    buildSeq(op, di[4], cznArr[1]);
    opcode = op;
    DiToCU = di;
    for (int i = 0; i < expQ.size(); i++) begin
      CznToCU = cznArr[i];
      if (i == abortAt) begin
        #2 rst = 1'b0;
        #1 checkEq($sformatf("rstAsync_op%0d", op), observed, '0);
        @(negedge clk) checkEq("rstHoldA", observed, '0);
        @(posedge clk) #1 checkEq("rstHoldB", observed, '0);
        @(negedge clk) checkEq("rstHoldC", observed, '0);
        @(posedge clk) #1 rst = 1'b1;
        return;
      end
      @(negedge clk) checkEq($sformatf("op%0d_di%02h_cyc%0d", op, di, i), observed, expQ[i]);
      @(posedge clk) #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b0;
    opcode  = '0;
    DiToCU  = '0;
    CznToCU = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1;
      opcode  = 3'($urandom_range(0, 7));
      DiToCU  = 5'($urandom_range(0, 31));
      CznToCU = 3'($urandom_range(0, 7));
      @(negedge clk) checkEq($sformatf("reset%0d", i), observed, '0);
    end
    @(posedge clk) #1 rst = 1'b1;

    runInstr(3'b000, 5'h03, 1'b0, 3'b000, -1);        // LDA
    runInstr(3'b001, 5'h0a, 1'b0, 3'b000, -1);        // STA
    runInstr(3'b101, 5'h00, 1'b1, 3'b010, -1);        // JZ taken
    runInstr(3'b101, 5'h00, 1'b1, 3'b000, -1);        // JZ not taken
    runInstr(3'b110, 5'h00, 1'b1, 3'b001, -1);        // JC taken
    runInstr(3'b110, 5'h00, 1'b1, 3'b110, -1);        // JC not taken
    runInstr(3'b111, 5'b1_10_01, 1'b0, 3'b000, -1);   // register AND
    runInstr(3'b111, 5'b0_01_10, 1'b0, 3'b000, -1);   // register ADD
    runInstr(3'b010, 5'h05, 1'b0, 3'b000, 3);         // ADD, reset in EXEC
    runInstr(3'b011, 5'h11, 1'b0, 3'b000, -1);        // AND after restart

    for (int n = 0; n < 60; n++)
      runInstr(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'b0, 3'b000, -1);

    runInstr(3'b100, 5'h1f, 1'b0, 3'b000, 2);         // JMP, reset in JUMP
    runInstr(3'b000, 5'h00, 1'b0, 3'b000, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
